// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and state encoding for the instruction-fetch
// sequencer (fetch_ctrl) and its PC sub-block (fetch_pc).
//   FETCH_ADDR_W      default PC / instruction-memory address width
//   FETCH_DATA_W      default instruction width
//   FETCH_RESET_PC    PC value after reset
//   FETCH_HALT_OPCODE opcode that halts fetch when FETCH_HALT_EN is defined
//   fetch_state_t     sequencer states IDLE / RUN / HALT
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W      = 8;
  localparam int unsigned FETCH_DATA_W      = 8;
  localparam logic [7:0]  FETCH_RESET_PC    = 8'h00;
  localparam logic [7:0]  FETCH_HALT_OPCODE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/fetch_pc.sv
// fetch_pc: program-counter register for the fetch sequencer.
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (pc <= RESET_PC)
//   load       in   load load_addr (branch redirect); wins over inc
//   load_addr  in   ADDR_W redirect target
//   inc        in   advance pc by one (instruction issued)
//   pc         out  ADDR_W current program counter
// Increment wraps modulo 2^ADDR_W with no carry out.
module fetch_pc import fetch_pkg::*; #(
  parameter int unsigned          ADDR_W   = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule : fetch_pc

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for a combinational instruction
// memory. Owns the PC (via fetch_pc), drives the memory address and registers
// each fetched byte toward decode over a valid/ready handshake.
//   clk, rst_n              clock, asynchronous active-low reset
//   start, stop             pulses: begin fetching / return to IDLE
//   redirect_valid/_addr    branch redirect (flushes the output register)
//   imem_addr, imem_instr   memory address (= pc) and same-cycle read data
//   out_valid/_ready        handshake toward decode
//   out_instr, out_pc       registered instruction and its fetch address
//   busy, halted            state != IDLE, state == HALT
// Build option: define FETCH_HALT_EN to make HALT_OPCODE stop fetching
// (HALT state); otherwise HALT is unreachable and halted is tied low.
module fetch_ctrl import fetch_pkg::*; #(
  parameter int unsigned       ADDR_W      = FETCH_ADDR_W,
  parameter int unsigned       DATA_W      = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(FETCH_RESET_PC),
  parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(FETCH_HALT_OPCODE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy,
  output logic              halted
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] pc;
  logic              issue;
  logic              halt_hit;

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (redirect_valid),
    .load_addr (redirect_addr),
    .inc       (issue),
    .pc        (pc)
  );

  assign imem_addr = pc;

  // Redirect and stop both suppress issue; the output slot is free when it
  // is empty or being accepted this cycle.
  always_comb begin
    issue = (state == RUN) && (!out_valid || out_ready) &&
            !redirect_valid && !stop;
  end

`ifdef FETCH_HALT_EN
  always_comb begin
    halt_hit = issue && (imem_instr == HALT_OPCODE);
  end
  assign halted = (state == HALT);
`else
  logic unused_halt_opcode;
  assign unused_halt_opcode = ^HALT_OPCODE;
  always_comb begin
    halt_hit = 1'b0;
  end
  assign halted = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Redirect never changes IDLE; stop beats redirect for the state while the
  // PC still takes the redirect target.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!redirect_valid && !stop && start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (halt_hit) begin
          state_next = HALT;
        end
      end
      HALT: begin
        if (stop) begin
          state_next = IDLE;
        end else if (redirect_valid) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output register: flush on redirect, load on issue, drop on accept,
  // otherwise hold (covers the stall and stop-with-pending cases).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_instr <= imem_instr;
      out_pc    <= pc;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed, table-driven bench for fetch_ctrl with a
// combinational 256 x 8 instruction memory model.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, redirect_valid, out_ready;
  logic [7:0] redirect_addr;
  logic [7:0] imem_addr, imem_instr;
  logic       out_valid;
  logic [7:0] out_instr, out_pc;
  logic       busy, halted;

  logic [7:0] mem [256];
  int         n_checks = 0;
  int         n_fail   = 0;

`ifdef FETCH_HALT_EN
  localparam logic HALT_ON = 1'b1;
`else
  localparam logic HALT_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr];

  fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stop           (stop),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .busy           (busy),
    .halted         (halted)
  );

  typedef struct {
    logic       st, sp, rv;
    logic [7:0] ra;
    logic       rdy;
    logic       ev;
    logic [7:0] ei, ep, ea;
    logic       eb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic sp, input logic rv,
                     input logic [7:0] ra, input logic rdy, input logic ev,
                     input logic [7:0] ei, input logic [7:0] ep,
                     input logic [7:0] ea, input logic eb);
    vec_t v;
    v.st = st; v.sp = sp; v.rv = rv; v.ra = ra; v.rdy = rdy;
    v.ev = ev; v.ei = ei; v.ep = ep; v.ea = ea; v.eb = eb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic sp, input logic rv,
                      input logic [7:0] ra, input logic rdy);
    start = st; stop = sp; redirect_valid = rv; redirect_addr = ra;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [7:0] ei,
                         input logic [7:0] ep, input logic [7:0] ea,
                         input logic eb, input logic eh);
    chk({tag, " out_valid"}, out_valid, ev);
    if (ev) begin
      chk({tag, " out_instr"}, out_instr, ei);
      chk({tag, " out_pc"}, out_pc, ep);
    end
    chk({tag, " imem_addr"}, imem_addr, ea);
    chk({tag, " busy"}, busy, eb);
    chk({tag, " halted"}, halted, eh);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

    //   st sp rv  ra    rdy ev  instr  pc     addr   busy
    add(1, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 1); // start -> RUN
    add(0, 0, 0, 8'h00, 1, 1, 8'h11, 8'h00, 8'h01, 1); // first valid
    add(0, 0, 0, 8'h00, 1, 1, 8'h22, 8'h01, 8'h02, 1);
    add(0, 0, 0, 8'h00, 0, 1, 8'h22, 8'h01, 8'h02, 1); // stall x3
    add(0, 0, 0, 8'h00, 0, 1, 8'h22, 8'h01, 8'h02, 1);
    add(0, 0, 0, 8'h00, 0, 1, 8'h22, 8'h01, 8'h02, 1);
    add(0, 0, 0, 8'h00, 1, 1, 8'h33, 8'h02, 8'h03, 1); // release
    add(0, 0, 1, 8'h80, 1, 0, 8'h00, 8'h00, 8'h80, 1); // flush 33
    add(0, 0, 0, 8'h00, 1, 1, 8'h25, 8'h80, 8'h81, 1);
    add(0, 0, 0, 8'h00, 1, 1, 8'h24, 8'h81, 8'h82, 1);
    add(0, 0, 1, 8'hFE, 1, 0, 8'h00, 8'h00, 8'hFE, 1); // redirect FE
    add(0, 0, 0, 8'h00, 1, 1, 8'h5B, 8'hFE, 8'hFF, 1);
    add(0, 0, 0, 8'h00, 1, 1, 8'h5A, 8'hFF, 8'h00, 1); // wrap
    add(0, 0, 0, 8'h00, 1, 1, 8'h11, 8'h00, 8'h01, 1);
    add(0, 1, 0, 8'h00, 0, 1, 8'h11, 8'h00, 8'h01, 0); // stop keeps pending
    add(1, 1, 0, 8'h00, 0, 1, 8'h11, 8'h00, 8'h01, 0); // start+stop: idle
    add(0, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 8'h01, 0); // accepted, no issue
    add(0, 0, 1, 8'h10, 1, 0, 8'h00, 8'h00, 8'h10, 0); // redirect in IDLE
    add(1, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 8'h10, 1);
    add(1, 0, 0, 8'h00, 1, 1, 8'hB5, 8'h10, 8'h11, 1); // start ignored
    add(0, 1, 1, 8'h40, 1, 0, 8'h00, 8'h00, 8'h40, 0); // stop + redirect
    add(0, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 8'h40, 0);

    start = 0; stop = 0; redirect_valid = 0; redirect_addr = '0; out_ready = 0;
    rst_n = 1'b0;
    #1;
    chk_out("reset", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("reset out_instr", out_instr, 8'h00);
    chk("reset out_pc", out_pc, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].st, vecs[i].sp, vecs[i].rv, vecs[i].ra, vecs[i].rdy);
      chk_out($sformatf("v%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].ep,
              vecs[i].ea, vecs[i].eb, 1'b0);
    end

    // Halt opcode at address 5 (only special with FETCH_HALT_EN).
    mem[5] = 8'hFF;
    step(0, 0, 1, 8'h03, 1); chk_out("h0", 0, 8'h00, 8'h00, 8'h03, 0, 0);
    step(1, 0, 0, 8'h00, 1); chk_out("h1", 0, 8'h00, 8'h00, 8'h03, 1, 0);
    step(0, 0, 0, 8'h00, 1); chk_out("h2", 1, 8'h44, 8'h03, 8'h04, 1, 0);
    step(0, 0, 0, 8'h00, 1); chk_out("h3", 1, 8'hA1, 8'h04, 8'h05, 1, 0);
    step(0, 0, 0, 8'h00, 1); chk_out("h4", 1, 8'hFF, 8'h05, 8'h06, 1, HALT_ON);
    step(0, 0, 0, 8'h00, 1);
    if (HALT_ON) chk_out("h5", 0, 8'h00, 8'h00, 8'h06, 1, 1);
    else         chk_out("h5", 1, 8'hA3, 8'h06, 8'h07, 1, 0);
    step(0, 0, 1, 8'h00, 1); chk_out("h6", 0, 8'h00, 8'h00, 8'h00, 1, 0);
    step(0, 0, 0, 8'h00, 1); chk_out("h7", 1, 8'h11, 8'h00, 8'h01, 1, 0);
    step(0, 0, 0, 8'h00, 1); chk_out("h8", 1, 8'h22, 8'h01, 8'h02, 1, 0);

    // Asynchronous reset mid-RUN with a valid output pending.
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("arst", 0, 8'h00, 8'h00, 8'h00, 0, 0);
    chk("arst out_instr", out_instr, 8'h00);
    chk("arst out_pc", out_pc, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 8'h00, 1); chk_out("post", 0, 8'h00, 8'h00, 8'h00, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_ctrl
